// File: rtl/fir_xifu_pkg.sv
// Shared types for the FIR XIFU pipeline: opcode enum and the writeback-queue entry.
package fir_xifu_pkg;

  typedef enum logic [1:0] {
    XIFU_NONE     = 2'd0,
    XIFU_XFIRLW   = 2'd1,
    XIFU_XFIRSW   = 2'd2,
    XIFU_XFIRDOTP = 2'd3
  } fir_xifu_instr_t;

  // Entry fields are sized for the widest queue configuration this package supports.
  localparam int WBQ_XLEN_W  = 32;
  localparam int WBQ_ID_W    = 4;
  localparam int WBQ_RF_AW_W = 5;

  typedef struct packed {
    fir_xifu_instr_t          instr;
    logic [WBQ_ID_W-1:0]      id;
    logic [WBQ_RF_AW_W-1:0]   rd;
    logic [WBQ_RF_AW_W-1:0]   rs1;
    logic [WBQ_XLEN_W-1:0]    result;
    logic [WBQ_XLEN_W-1:0]    rdata;
    logic                     data_ok;
  } fir_xifu_wbq_entry_t;

  function automatic logic wbq_is_mem(input fir_xifu_instr_t instr);
    return (instr == XIFU_XFIRLW) || (instr == XIFU_XFIRSW);
  endfunction

endpackage

// File: rtl/fir_xifu_wbq_ptr.sv
// Queue index register that wraps modulo DEPTH (DEPTH is a power of two).
module fir_xifu_wbq_ptr #(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [AW-1:0] ptr_o
);

  logic [AW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i)      ptr_d = '0;
    else if (inc_i) ptr_d = ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fir_xifu_wb_queue.sv
// In-order writeback queue: pairs LW/SW entries with in-order memory results and
// retires entries through the core result handshake plus an XIFU regfile write.
module fir_xifu_wb_queue
  import fir_xifu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int ID_W  = 4,
  parameter int RF_AW = 5
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       ex2wb_valid_i,
  output logic                       ex2wb_ready_o,
  input  fir_xifu_instr_t            ex2wb_instr_i,
  input  logic [ID_W-1:0]            ex2wb_id_i,
  input  logic [RF_AW-1:0]           ex2wb_rd_i,
  input  logic [RF_AW-1:0]           ex2wb_rs1_i,
  input  logic [XLEN-1:0]            ex2wb_result_i,
  input  logic                       mem_result_valid_i,
  input  logic [ID_W-1:0]            mem_result_id_i,
  input  logic [XLEN-1:0]            mem_result_rdata_i,
  output logic                       result_valid_o,
  input  logic                       result_ready_i,
  output logic [ID_W-1:0]            result_id_o,
  output logic [XLEN-1:0]            result_data_o,
  output logic [RF_AW-1:0]           result_rd_o,
  output logic                       result_we_o,
  output logic                       rf_write_o,
  output logic [RF_AW-1:0]           rf_rd_o,
  output logic [XLEN-1:0]            rf_wdata_o,
  input  logic                       flush_i,
  output logic                       err_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fir_xifu_wbq_entry_t ent_q [DEPTH];
  fir_xifu_wbq_entry_t head, new_ent;
  logic [DEPTH-1:0]    vld_q, vld_d;
  logic [CW-1:0]       count_q, count_d;
  logic                err_q, err_d;
  logic [AW-1:0]       head_ptr, tail_ptr, mem_ptr;
  logic                full, push, pop, mem_adv;
  logic                mem_hit, mem_match, mem_ok, stop;
  logic [AW-1:0]       mem_idx, match_idx, idx;
  logic [ID_W-1:0]     match_id;

  assign full          = (count_q == FULL_CNT);
  assign ex2wb_ready_o = !full;
  assign push          = ex2wb_valid_i && !full && (ex2wb_instr_i != XIFU_NONE) && !flush_i;
  assign head          = ent_q[head_ptr];
  assign result_valid_o = vld_q[head_ptr] && head.data_ok;
  assign pop           = result_valid_o && result_ready_i && !flush_i;
  // mem_ptr only marks where the search may start; it trails by a cycle over completed entries.
  assign mem_adv       = vld_q[mem_ptr] && ent_q[mem_ptr].data_ok;

  fir_xifu_wbq_ptr #(.DEPTH(DEPTH)) u_head_ptr (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(flush_i), .inc_i(pop),     .ptr_o(head_ptr));
  fir_xifu_wbq_ptr #(.DEPTH(DEPTH)) u_tail_ptr (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(flush_i), .inc_i(push),    .ptr_o(tail_ptr));
  fir_xifu_wbq_ptr #(.DEPTH(DEPTH)) u_mem_ptr (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(flush_i), .inc_i(mem_adv), .ptr_o(mem_ptr));

  // Oldest resident entry still waiting for load/store data.
  always_comb begin
    mem_hit = 1'b0;
    mem_idx = mem_ptr;
    stop    = 1'b0;
    idx     = mem_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = mem_ptr + AW'(i);
      if (!stop && !mem_hit) begin
        if (!vld_q[idx])              stop = 1'b1;
        else if (!ent_q[idx].data_ok) begin
          mem_hit = 1'b1;
          mem_idx = idx;
        end
      end
    end
  end

  always_comb begin
    mem_match = 1'b0;
    match_idx = mem_idx;
    match_id  = '0;
    if (mem_hit) begin
      mem_match = 1'b1;
      match_id  = ent_q[mem_idx].id[ID_W-1:0];
    end else if (push && wbq_is_mem(ex2wb_instr_i)) begin
      mem_match = 1'b1;
      match_idx = tail_ptr;
      match_id  = ex2wb_id_i;
    end
  end

  assign mem_ok = mem_result_valid_i && !flush_i && mem_match && (match_id == mem_result_id_i);
  assign err_d  = err_q | (mem_result_valid_i && !flush_i && !mem_ok);

  always_comb begin
    new_ent         = '0;
    new_ent.instr   = ex2wb_instr_i;
    new_ent.id      = WBQ_ID_W'(ex2wb_id_i);
    new_ent.rd      = WBQ_RF_AW_W'(ex2wb_rd_i);
    new_ent.rs1     = WBQ_RF_AW_W'(ex2wb_rs1_i);
    new_ent.result  = WBQ_XLEN_W'(ex2wb_result_i);
    new_ent.data_ok = (ex2wb_instr_i == XIFU_XFIRDOTP);
  end

  // Payload storage is not reset; vld_q qualifies every entry.
  always_ff @(posedge clk_i) begin
    if (push) ent_q[tail_ptr] <= new_ent;
    if (mem_ok) begin
      ent_q[match_idx].rdata   <= WBQ_XLEN_W'(mem_result_rdata_i);
      ent_q[match_idx].data_ok <= 1'b1;
    end
  end

  always_comb begin
    vld_d   = vld_q;
    count_d = count_q;
    if (flush_i) begin
      vld_d   = '0;
      count_d = '0;
    end else begin
      if (push) vld_d[tail_ptr] = 1'b1;
      if (pop)  vld_d[head_ptr] = 1'b0;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      vld_q   <= vld_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    result_id_o   = '0;
    result_data_o = '0;
    result_rd_o   = '0;
    result_we_o   = 1'b0;
    rf_write_o    = 1'b0;
    rf_rd_o       = '0;
    rf_wdata_o    = '0;
    if (result_valid_o) begin
      result_id_o   = head.id[ID_W-1:0];
      result_data_o = head.result[XLEN-1:0];
      if (wbq_is_mem(head.instr)) begin
        result_rd_o = head.rs1[RF_AW-1:0];
        result_we_o = 1'b1;
      end
      if (pop && (head.instr != XIFU_XFIRSW)) begin
        rf_write_o = 1'b1;
        rf_rd_o    = head.rd[RF_AW-1:0];
        rf_wdata_o = (head.instr == XIFU_XFIRLW) ? head.rdata[XLEN-1:0] : head.result[XLEN-1:0];
      end
    end
  end

  assign err_o   = err_q;
  assign count_o = count_q;

endmodule
